// File: rtl/dog_action_sequencer_if.sv
// Interface bundling the run controls, raw buttons, status and display lines
// of the dog action sequencer. The master drives controls; the slave is the block.
interface dog_action_sequencer_if #(
  parameter int unsigned SPD_W = 2,
  parameter int unsigned ACT_W = 3
);
  logic             enable;
  logic             btn_speed_n;
  logic             btn_rst_act;
  logic             one_shot;
  logic [SPD_W-1:0] speed;
  logic [ACT_W-1:0] action;
  logic             act_stb;
  logic             done;
  logic [3:0]       dig_n;
  logic [7:0]       seg_n;

  modport master (
    output enable, btn_speed_n, btn_rst_act, one_shot,
    input  speed, action, act_stb, done, dig_n, seg_n
  );

  modport slave (
    input  enable, btn_speed_n, btn_rst_act, one_shot,
    output speed, action, act_stb, done, dig_n, seg_n
  );
endinterface

// File: rtl/dog_action_sequencer.sv
// Toy-dog action sequencer: debounced speed button, speed-dependent action
// stepping with loop/one-shot modes, pause, and a 4-digit multiplexed display.
// Single clock throughout; slow rates come from clock enables.
module dog_action_sequencer #(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned N_SPEEDS      = 4,
  parameter int unsigned BASE_DIV_BITS = 24,
  parameter int unsigned N_ACTIONS     = 8,
  parameter int unsigned SCAN_BITS     = 16
) (
  input logic                   clk,
  input logic                   reset,
  dog_action_sequencer_if.slave bus
);

  localparam int unsigned SPD_W  = (N_SPEEDS > 2) ? $clog2(N_SPEEDS) : 1;
  localparam int unsigned ACT_W  = (N_ACTIONS > 2) ? $clog2(N_ACTIONS) : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  // Longest period (level 1) is 2^(BASE_DIV_BITS+N_SPEEDS-2) cycles
  localparam int unsigned PER_W  = (BASE_DIV_BITS + N_SPEEDS > 2) ?
                                   (BASE_DIV_BITS + N_SPEEDS - 2) : 1;
  localparam int unsigned SCAN_W = SCAN_BITS + 2;

  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(N_SPEEDS - 1);
  localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(N_ACTIONS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_ONES = '1;

  logic [1:0]       btn_sync, rst_sync, os_sync;
  logic             btn_s, rst_s, os_s, en;
  logic             deb_state, deb_state_d, press;
  logic [DEB_W-1:0] deb_cnt;
  logic [SPD_W-1:0] speed_q, shamt;
  logic [PER_W-1:0] per_cnt, period_m1;
  logic             tick_c;
  logic [ACT_W-1:0] action_q;
  logic             stb_q, done_q;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]       digit_c;
  logic [3:0]       dig_q;
  logic [7:0]       seg_q, seg_c;

  assign btn_s = btn_sync[1];
  assign rst_s = rst_sync[1];
  assign os_s  = os_sync[1];
  assign en    = bus.enable;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Two-flop synchronisers for the asynchronous inputs; never paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= 2'b11;
      rst_sync <= 2'b00;
      os_sync  <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], bus.btn_speed_n};
      rst_sync <= {rst_sync[0], bus.btn_rst_act};
      os_sync  <= {os_sync[0],  bus.one_shot};
    end
  end

  // Debouncer; the press pulse is registered once more off the stable state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_state   <= 1'b1;
      deb_state_d <= 1'b1;
      deb_cnt     <= '0;
      press       <= 1'b0;
    end else if (en) begin
      deb_state_d <= deb_state;
      press       <= deb_state_d & ~deb_state;
      if (btn_s != deb_state) begin
        if (deb_cnt == DEB_LAST) begin
          deb_state <= btn_s;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Tick when the period counter hits period-1 for the current level
  always_comb begin
    shamt     = speed_q - SPD_W'(1);
    period_m1 = PER_ONES >> shamt;
    tick_c    = en && (speed_q != '0) && (per_cnt == period_m1);
  end

  // Speed level and period counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= '0;
      per_cnt <= '0;
    end else if (en) begin
      if (press) speed_q <= (speed_q == SPD_MAX) ? '0 : speed_q + SPD_W'(1);
      if (press || rst_s || (speed_q == '0) || tick_c) per_cnt <= '0;
      else                                              per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // Action stepping, one-shot completion and change strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      action_q <= '0;
      stb_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (en) begin
        if (rst_s) begin
          action_q <= '0;
          done_q   <= 1'b0;
        end else begin
          if (tick_c) begin
            if (os_s && (action_q == ACT_LAST)) begin
              done_q <= 1'b1;
            end else begin
              action_q <= (action_q == ACT_LAST) ? '0 : action_q + ACT_W'(1);
              stb_q    <= 1'b1;
            end
          end
          if (!os_s) done_q <= 1'b0;
        end
      end
    end
  end

  // Segment pattern for the digit currently selected by the scan counter
  always_comb begin
    digit_c = scan_cnt[SCAN_W-1 -: 2];
    seg_c   = 8'hFF;
    unique case (digit_c)
      2'd0: seg_c = hex7(4'(speed_q));
      2'd1: seg_c = hex7(4'(action_q));
      2'd2: seg_c = done_q ? 8'hA1 : 8'hFF;
      2'd3: seg_c = os_s ? 8'hF9 : 8'hC7;
    endcase
  end

  // Scan counter and registered display drive; blank while paused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      dig_q    <= 4'hF;
      seg_q    <= 8'hFF;
    end else if (en) begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      dig_q    <= ~(4'b0001 << digit_c);
      seg_q    <= seg_c;
    end else begin
      dig_q <= 4'hF;
      seg_q <= 8'hFF;
    end
  end

  assign bus.speed   = speed_q;
  assign bus.action  = action_q;
  assign bus.act_stb = stb_q;
  assign bus.done    = done_q;
  assign bus.dig_n   = dig_q;
  assign bus.seg_n   = seg_q;

endmodule

// File: tb/tb_dog_action_sequencer.sv
// Bench for dog_action_sequencer: directed scenarios plus a random phase, all
// compared every cycle against a behavioural model of the rules.
module tb_dog_action_sequencer;

  localparam int DEB = 4, NS = 4, BDB = 3, NA = 8, SB = 2;

  logic clk, rst;
  int   checks = 0, failures = 0;

  dog_action_sequencer_if #(.SPD_W(2), .ACT_W(3)) bus ();

  dog_action_sequencer #(
    .DEB_CYCLES(DEB), .N_SPEEDS(NS), .BASE_DIV_BITS(BDB),
    .N_ACTIONS(NA), .SCAN_BITS(SB)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  bit   q_btn[$], q_ra[$], q_os[$];
  bit   s_btn, s_ra, s_os, m_tick, m_chg;
  bit   m_stable = 1, m_done = 0, m_stb = 0;
  int   m_speed = 0, m_action = 0, m_elapsed = 0, m_run = 0, m_pend = 0, m_scan = 0, k;
  logic [3:0] m_dig = 4'hF;
  logic [7:0] m_seg = 8'hFF;

  function automatic int period_of(input int s);
    return 1 << (BDB + NS - 1 - s);
  endfunction

  task automatic m_reset();
    q_btn = '{1'b1, 1'b1}; q_ra = '{1'b0, 1'b0}; q_os = '{1'b0, 1'b0};
    m_stable = 1; m_done = 0; m_stb = 0; m_speed = 0; m_action = 0;
    m_elapsed = 0; m_run = 0; m_pend = 0; m_scan = 0; m_dig = 4'hF; m_seg = 8'hFF;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      // synchronised value seen now is the raw sample from two edges back
      q_btn.push_back(bus.btn_speed_n); q_ra.push_back(bus.btn_rst_act); q_os.push_back(bus.one_shot);
      s_btn = q_btn.pop_front(); s_ra = q_ra.pop_front(); s_os = q_os.pop_front();
      if (!bus.enable) begin
        m_stb = 0; m_dig = 4'hF; m_seg = 8'hFF;
      end else begin
        k = (m_scan / (1 << SB)) % 4;
        m_scan++;
        m_dig = ~(4'b0001 << k);
        case (k)
          0:       m_seg = hex_tab[m_speed];
          1:       m_seg = hex_tab[m_action];
          2:       m_seg = m_done ? 8'hA1 : 8'hFF;
          default: m_seg = s_os ? 8'hF9 : 8'hC7;
        endcase
        m_tick = (m_speed != 0) && (((m_elapsed + 1) % period_of(m_speed)) == 0);
        m_chg  = 0;
        if (m_pend > 0) begin m_pend--; m_chg = (m_pend == 0); end
        if (s_btn != m_stable) begin
          m_run++;
          if (m_run == DEB) begin
            m_stable = s_btn; m_run = 0;
            if (!s_btn) m_pend = 2;
          end
        end else m_run = 0;
        if (m_chg || s_ra || m_speed == 0) m_elapsed = 0;
        else                               m_elapsed++;
        if (m_chg) m_speed = (m_speed + 1) % NS;
        m_stb = 0;
        if (s_ra) begin
          m_action = 0; m_done = 0;
        end else begin
          if (m_tick) begin
            if (s_os && m_action == NA - 1) m_done = 1;
            else begin m_action = (m_action + 1) % NA; m_stb = 1; end
          end
          if (!s_os) m_done = 0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    chk("speed",   32'(bus.speed),   32'(m_speed));
    chk("action",  32'(bus.action),  32'(m_action));
    chk("act_stb", 32'(bus.act_stb), 32'(m_stb));
    chk("done",    32'(bus.done),    32'(m_done));
    chk("dig_n",   32'(bus.dig_n),   32'(m_dig));
    chk("seg_n",   32'(bus.seg_n),   32'(m_seg));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_speed"},   32'(bus.speed),   32'd0);
    chk({tag, "_action"},  32'(bus.action),  32'd0);
    chk({tag, "_act_stb"}, 32'(bus.act_stb), 32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_dig_n"},   32'(bus.dig_n),   32'hF);
    chk({tag, "_seg_n"},   32'(bus.seg_n),   32'hFF);
  endtask

  task automatic run(input int n);
    repeat (n) tick_check();
  endtask

  task automatic run_count(input int n, output int c);
    c = 0;
    repeat (n) begin tick_check(); if (bus.act_stb === 1'b1) c++; end
  endtask

  task automatic wait_stb(input int budget, output int n);
    n = 0;
    do begin tick_check(); n++; end while (bus.act_stb !== 1'b1 && n < budget);
    if (bus.act_stb !== 1'b1) chk("stb_timeout", 32'(bus.act_stb), 32'd1);
  endtask

  task automatic wait_action(input int target);
    int n;
    for (int i = 0; i < 20 && bus.action != 3'(target); i++) wait_stb(40, n);
    chk("reach_action", 32'(bus.action), 32'(target));
  endtask

  task automatic press();
    bus.btn_speed_n = 1'b0; run(10);
    bus.btn_speed_n = 1'b1; run(10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c, sa, ss, ce, cd, cb, c7;
    logic [7:0] exp_seg;
    rst = 1'b1;
    bus.enable = 1'b1; bus.btn_speed_n = 1'b1; bus.btn_rst_act = 1'b0; bus.one_shot = 1'b0;
    repeat (3) begin tick_check(); chk_reset_vals("rst"); end
    rst = 1'b0;
    run(5);

    // short glitch is rejected
    bus.btn_speed_n = 1'b0; run(3);
    bus.btn_speed_n = 1'b1; run(12);
    chk("glitch_speed", 32'(bus.speed), 32'd0);

    // press latency: speed changes at edge DEB+3, exactly once
    bus.btn_speed_n = 1'b0; run(7);
    chk("press_e6", 32'(bus.speed), 32'd0);
    run(1);
    chk("press_e7", 32'(bus.speed), 32'd1);
    run(2);
    bus.btn_speed_n = 1'b1; run(12);
    chk("press_once", 32'(bus.speed), 32'd1);

    // tick periods per level
    wait_stb(80, n); wait_stb(80, n);
    chk("period_s1", 32'(n), 32'd32);
    press(); wait_stb(80, n); wait_stb(80, n);
    chk("period_s2", 32'(n), 32'd16);
    press(); wait_stb(80, n); wait_stb(80, n);
    chk("period_s3", 32'(n), 32'd8);
    press();
    chk("speed_wrap", 32'(bus.speed), 32'd0);
    run_count(100, c);
    chk("s0_no_stb", 32'(c), 32'd0);

    // loop wrap at speed 3
    press(); press(); press();
    chk("speed3", 32'(bus.speed), 32'd3);
    wait_action(7);
    wait_stb(20, n);
    chk("loop_wrap", 32'(bus.action), 32'd0);

    // one-shot stops at the last action
    bus.one_shot = 1'b1; run(3);
    wait_action(7);
    run_count(9, c);
    chk("oneshot_done", 32'(bus.done), 32'd1);
    run_count(40, n);
    chk("oneshot_no_stb", 32'(c + n), 32'd0);
    chk("oneshot_hold", 32'(bus.action), 32'd7);

    // action clear
    bus.btn_rst_act = 1'b1; run(3);
    chk("rstact_action", 32'(bus.action), 32'd0);
    chk("rstact_done",   32'(bus.done),   32'd0);
    bus.btn_rst_act = 1'b0; run(3);
    bus.one_shot = 1'b0; run(3);

    // action clear landing on a tick edge overrides the tick
    wait_stb(20, n);
    run(5);
    bus.btn_rst_act = 1'b1; run(1);
    bus.btn_rst_act = 1'b0; run(2);
    chk("rst_tick_action", 32'(bus.action),  32'd0);
    chk("rst_tick_stb",    32'(bus.act_stb), 32'd0);

    // pause and resume at the remaining count
    wait_stb(20, n);
    run(3);
    sa = int'(bus.action); ss = int'(bus.speed);
    bus.enable = 1'b0;
    repeat (20) begin tick_check(); chk("pause_dig", 32'(bus.dig_n), 32'hF); end
    chk("pause_action", 32'(bus.action), 32'(sa));
    chk("pause_speed",  32'(bus.speed),  32'(ss));
    bus.enable = 1'b1;
    wait_stb(20, n);
    chk("resume_remaining", 32'(n), 32'd5);

    // display rotation at speed 2, action 5, loop mode
    press(); press(); press();
    chk("speed2", 32'(bus.speed), 32'd2);
    wait_action(5);
    ce = 0; cd = 0; cb = 0; c7 = 0;
    repeat (15) begin
      tick_check();
      case (bus.dig_n)
        4'hE: begin exp_seg = 8'hA4; ce++; end
        4'hD: begin exp_seg = 8'h92; cd++; end
        4'hB: begin exp_seg = 8'hFF; cb++; end
        4'h7: begin exp_seg = 8'hC7; c7++; end
        default: exp_seg = 8'h00;
      endcase
      chk("disp_seg", 32'(bus.seg_n), 32'(exp_seg));
    end
    chk("disp_rotation", 32'(ce >= 3 && cd >= 3 && cb >= 3 && c7 >= 3), 32'd1);

    // reset mid-run takes effect immediately
    rst = 1'b1; #1;
    chk_reset_vals("midrst");
    tick_check();
    rst = 1'b0;
    run_count(40, c);
    chk("post_rst_no_stb", 32'(c), 32'd0);
    chk("post_rst_action", 32'(bus.action), 32'd0);

    // random phase against the model
    for (int sg = 0; sg < 150; sg++) begin
      bus.btn_speed_n = 1'($urandom_range(0, 1));
      bus.enable      = ($urandom_range(0, 9) != 0);
      bus.btn_rst_act = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) bus.one_shot = ~bus.one_shot;
      run(int'($urandom_range(1, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
